gol_engine: RTL

//  Parametrised, memory-based Game of Life engine that replaces the per-cell generate array.

---
 rtl/gol_engine_if.sv | 43 ++++
 rtl/gol_engine.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/gol_engine_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | gol_engine_if: control, seed-write, pixel-read and status bundle          |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface gol_engine_if #(
    parameter int WIDTH  = 80,
    parameter int HEIGHT = 60,
    parameter int GEN_W  = 16
);
    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);
    localparam int PW = $clog2(WIDTH * HEIGHT + 1);

    logic             step;
    logic             clear;
    logic [8:0]       birth_mask;
    logic [8:0]       survive_mask;
    logic             wr_en;
    logic [XW-1:0]    wr_x;
    logic [YW-1:0]    wr_y;
    logic             wr_data;
    logic [XW-1:0]    rd_x;
    logic [YW-1:0]    rd_y;
    logic             rd_cell;
    logic             busy;
    logic             done;
    logic [GEN_W-1:0] gen_count;
    logic [PW-1:0]    pop_count;

    modport master (
        output step, clear, birth_mask, survive_mask,
        output wr_en, wr_x, wr_y, wr_data, rd_x, rd_y,
        input  rd_cell, busy, done, gen_count, pop_count
    );

    modport slave (
        input  step, clear, birth_mask, survive_mask,
        input  wr_en, wr_x, wr_y, wr_data, rd_x, rd_y,
        output rd_cell, busy, done, gen_count, pop_count
    );
endinterface
`default_nettype wire

// File: rtl/gol_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | gol_engine: double-banked Game of Life grid, one row per cycle sweep      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module gol_engine #(
    parameter int WIDTH  = 80,
    parameter int HEIGHT = 60,
    parameter int WRAP   = 0,
    parameter int GEN_W  = 16
) (
    input wire          CLK,
    input wire          reset_n,
    gol_engine_if.slave bus
);
    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);
    localparam int PW = $clog2(WIDTH * HEIGHT + 1);
    localparam logic [YW-1:0] Y_MAX = YW'(HEIGHT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SWEEP = 2'd1,
        S_SWAP  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] bank_q [2][HEIGHT];
    logic [WIDTH-1:0] bank_d [2][HEIGHT];
    logic             bank_sel_q, bank_sel_d;
    logic [YW-1:0]    row_q, row_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [PW-1:0]    pop_q, pop_d;
    logic [GEN_W-1:0] gen_q, gen_d;
    logic             rd_cell_q, rd_cell_d;

    logic [WIDTH-1:0] row_up, row_mid, row_dn, row_next;
    logic [WIDTH+1:0] ext_up, ext_mid, ext_dn;
    logic [PW-1:0]    row_pop;
    logic [3:0]       nbr_cnt;

    // Pads a row with its left/right neighbour columns: bit 0 is column -1.
    function automatic logic [WIDTH+1:0] extend(input logic [WIDTH-1:0] r);
        logic lo, hi;
        lo = (WRAP != 0) ? r[WIDTH-1] : 1'b0;
        hi = (WRAP != 0) ? r[0]       : 1'b0;
        return {hi, r, lo};
    endfunction

    always_comb begin
        row_mid = bank_q[bank_sel_q][row_q];
        row_up  = '0;
        row_dn  = '0;
        if (row_q != '0)
            row_up = bank_q[bank_sel_q][row_q - 1'b1];
        else if (WRAP != 0)
            row_up = bank_q[bank_sel_q][Y_MAX];
        if (row_q != Y_MAX)
            row_dn = bank_q[bank_sel_q][row_q + 1'b1];
        else if (WRAP != 0)
            row_dn = bank_q[bank_sel_q][0];
    end

    assign ext_up  = extend(row_up);
    assign ext_mid = extend(row_mid);
    assign ext_dn  = extend(row_dn);

    always_comb begin
        row_next = '0;
        row_pop  = '0;
        nbr_cnt  = '0;
        for (int c = 0; c < WIDTH; c++) begin
            nbr_cnt = 4'(ext_up[c]) + 4'(ext_up[c+1]) + 4'(ext_up[c+2])
                    + 4'(ext_mid[c])                  + 4'(ext_mid[c+2])
                    + 4'(ext_dn[c]) + 4'(ext_dn[c+1]) + 4'(ext_dn[c+2]);
            row_next[c] = ext_mid[c+1] ? bus.survive_mask[nbr_cnt]
                                       : bus.birth_mask[nbr_cnt];
            row_pop = row_pop + PW'(row_next[c]);
        end
    end

    always_comb begin
        state_d    = state_q;
        bank_d     = bank_q;
        bank_sel_d = bank_sel_q;
        row_d      = row_q;
        acc_d      = acc_q;
        pop_d      = pop_q;
        gen_d      = gen_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.clear) begin
                    for (int r = 0; r < HEIGHT; r++)
                        bank_d[bank_sel_q][r] = '0;
                    gen_d = '0;
                    pop_d = '0;
                end else if (bus.step) begin
                    state_d = S_SWEEP;
                    row_d   = '0;
                    acc_d   = '0;
                end else if (bus.wr_en && (int'(bus.wr_x) < WIDTH) &&
                             (int'(bus.wr_y) < HEIGHT)) begin
                    bank_d[bank_sel_q][bus.wr_y][bus.wr_x] = bus.wr_data;
                end
            end
            S_SWEEP: begin
                // Only the shadow bank is written; the displayed bank stays intact.
                bank_d[~bank_sel_q][row_q] = row_next;
                acc_d = acc_q + row_pop;
                if (row_q == Y_MAX)
                    state_d = S_SWAP;
                else
                    row_d = row_q + 1'b1;
            end
            S_SWAP: begin
                bank_sel_d = ~bank_sel_q;
                pop_d      = acc_q;
                gen_d      = gen_q + 1'b1;
                row_d      = '0;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rd_cell_d = 1'b0;
        if ((int'(bus.rd_x) < WIDTH) && (int'(bus.rd_y) < HEIGHT))
            rd_cell_d = bank_q[bank_sel_q][bus.rd_y][bus.rd_x];
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            bank_q     <= '{default: '0};
            bank_sel_q <= 1'b0;
            row_q      <= '0;
            acc_q      <= '0;
            pop_q      <= '0;
            gen_q      <= '0;
            rd_cell_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            bank_q     <= bank_d;
            bank_sel_q <= bank_sel_d;
            row_q      <= row_d;
            acc_q      <= acc_d;
            pop_q      <= pop_d;
            gen_q      <= gen_d;
            rd_cell_q  <= rd_cell_d;
        end
    end

    assign bus.rd_cell   = rd_cell_q;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = (state_q == S_SWAP);
    assign bus.gen_count = gen_q;
    assign bus.pop_count = pop_q;

endmodule
`default_nettype wire
